// File: rtl/iir1_sequencer_pkg.sv
// iir_pkg: shared constants and helpers for the first-order IIR sequencer.
//   - Q16.16 format constants (DATA_W, FRAC_W, ONE) and saturation limits
//   - FSM state encodings and config-port address map
//   - reset values of the coefficient registers (pass-through filter)
//   - add_q(): DATA_W-wide add, saturating when IIR_SAT_EN is defined, else wrapping
// Build option: `define IIR_SAT_EN to enable saturation of adds and products.
package iir_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FRAC_W = 16;

  localparam logic [DATA_W-1:0] ONE     = 32'h0001_0000;
  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StMulA  = 3'd1;
  localparam state_t StMulB0 = 3'd2;
  localparam state_t StMulB1 = 3'd3;
  localparam state_t StDone  = 3'd4;

  localparam logic [2:0] CfgA1   = 3'd0;
  localparam logic [2:0] CfgB0   = 3'd1;
  localparam logic [2:0] CfgB1   = 3'd2;
  localparam logic [2:0] CfgXoff = 3'd3;
  localparam logic [2:0] CfgW0   = 3'd4;
  localparam logic [2:0] CfgClr  = 3'd5;

  localparam logic [DATA_W-1:0] RstA1   = '0;
  localparam logic [DATA_W-1:0] RstB0   = '0;
  localparam logic [DATA_W-1:0] RstB1   = ONE;
  localparam logic [DATA_W-1:0] RstXoff = '0;
  localparam logic [DATA_W-1:0] RstW0   = '0;

  function automatic logic [DATA_W-1:0] add_q(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
`ifdef IIR_SAT_EN
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Sign bit disagreeing with the guard bit means signed overflow.
    if (s[DATA_W] != s[DATA_W-1]) add_q = s[DATA_W] ? SAT_MIN : SAT_MAX;
    else                          add_q = s[DATA_W-1:0];
`else
    add_q = a + b;
`endif
  endfunction

endpackage

// File: rtl/iir1_sequencer_if.sv
// iir1_sequencer_if: sample in (valid/ready), config write port, result out (valid/ready).
//   master: sample source / config writer / result consumer
//   slave : the sequencer
interface iir1_sequencer_if;
  import iir_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [DATA_W-1:0] out_w;
  logic              busy;

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready,
    input  in_ready, out_valid, out_y, out_w, busy
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready,
    output in_ready, out_valid, out_y, out_w, busy
  );

endinterface

// File: rtl/iir1_sequencer_mul_q.sv
// iir_mul_q: combinational signed Q16.16 multiply.
//   a_i, b_i : signed operands
//   p_o      : floor((a_i*b_i) >> FRAC_W), saturated with IIR_SAT_EN, else bits [47:16]
module iir_mul_q
  import iir_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] p_o
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});

`ifdef IIR_SAT_EN
  logic signed [2*DATA_W-1:0] shifted;
  assign shifted = prod >>> FRAC_W;

  always_comb begin
    if (shifted > $signed({{DATA_W{1'b0}}, SAT_MAX}))      p_o = SAT_MAX;
    else if (shifted < $signed({{DATA_W{1'b1}}, SAT_MIN})) p_o = SAT_MIN;
    else                                                   p_o = shifted[DATA_W-1:0];
  end
`else
  logic unused_prod;
  assign unused_prod = ^{prod[2*DATA_W-1:FRAC_W+DATA_W], prod[FRAC_W-1:0]};
  assign p_o = prod[FRAC_W+DATA_W-1:FRAC_W];
`endif

endmodule

// File: rtl/iir1_sequencer.sv
// iir1_sequencer: first-order IIR section sequencer.
//   w[n] = (x[n] + xoff) + a1*w[n-1];  y[n] = b0*w[n-1] + b1*w[n]
// One shared multiplier/adder over IDLE -> MUL_A -> MUL_B0 -> MUL_B1 -> DONE.
// Ports: clk, rst (async, active-high), bus (iir1_sequencer_if.slave):
//   in_valid/in_ready/in_data, cfg_we/cfg_addr/cfg_wdata,
//   out_valid/out_ready/out_y/out_w, busy.
// Build option: IIR_SAT_EN selects saturating (defined) or wrapping (undefined) arithmetic.
module iir1_sequencer
  import iir_pkg::*;
(
  input logic             clk,
  input logic             rst,
  iir1_sequencer_if.slave bus
);

  state_t state_q, state_d;
  logic [DATA_W-1:0] a1_q, a1_d, b0_q, b0_d, b1_q, b1_d, xoff_q, xoff_d, w0_q, w0_d;
  logic [DATA_W-1:0] a1_sh_q, a1_sh_d, b0_sh_q, b0_sh_d, b1_sh_q, b1_sh_d;
  logic [DATA_W-1:0] xoff_sh_q, xoff_sh_d, x_q, x_d;
  logic [DATA_W-1:0] wprev_q, wprev_d, wacc_q, wacc_d, yacc_q, yacc_d;
  logic [DATA_W-1:0] out_y_q, out_y_d, out_w_q, out_w_d;
  logic              out_valid_q, out_valid_d, clr_pend_q, clr_pend_d;
  logic [DATA_W-1:0] mul_a, mul_b, mul_p;
  logic              accept;

  // Acceptance is blocked while a clear is pending so the clear lands before the next sample.
  assign bus.in_ready  = (state_q == StIdle) && !clr_pend_q && !rst;
  assign accept        = bus.in_valid && (state_q == StIdle) && !clr_pend_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_w     = out_w_q;
  assign bus.busy      = (state_q != StIdle);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMulA:  begin mul_a = a1_sh_q; mul_b = wprev_q; end
      StMulB0: begin mul_a = b0_sh_q; mul_b = wprev_q; end
      StMulB1: begin mul_a = b1_sh_q; mul_b = wacc_q;  end
      default: ;
    endcase
  end

  iir_mul_q u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    xoff_d      = xoff_q;
    w0_d        = w0_q;
    a1_sh_d     = a1_sh_q;
    b0_sh_d     = b0_sh_q;
    b1_sh_d     = b1_sh_q;
    xoff_sh_d   = xoff_sh_q;
    x_d         = x_q;
    wprev_d     = wprev_q;
    wacc_d      = wacc_q;
    yacc_d      = yacc_q;
    out_y_d     = out_y_q;
    out_w_d     = out_w_q;
    out_valid_d = out_valid_q;
    clr_pend_d  = clr_pend_q;

    case (state_q)
      StIdle: begin
        if (clr_pend_q) begin
          wprev_d    = w0_q;
          clr_pend_d = 1'b0;
        end
        if (accept) begin
          // Shadows take the pre-write values, so a same-cycle config write misses this sample.
          x_d       = bus.in_data;
          a1_sh_d   = a1_q;
          b0_sh_d   = b0_q;
          b1_sh_d   = b1_q;
          xoff_sh_d = xoff_q;
          state_d   = StMulA;
        end
      end
      StMulA: begin
        wacc_d  = add_q(add_q(x_q, xoff_sh_q), mul_p);
        state_d = StMulB0;
      end
      StMulB0: begin
        yacc_d  = mul_p;
        state_d = StMulB1;
      end
      StMulB1: begin
        yacc_d      = add_q(yacc_q, mul_p);
        out_y_d     = yacc_d;
        out_w_d     = wacc_q;
        out_valid_d = 1'b1;
        wprev_d     = wacc_q;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // After the FSM so a new clear request wins over the one being retired.
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        CfgA1:   a1_d       = bus.cfg_wdata;
        CfgB0:   b0_d       = bus.cfg_wdata;
        CfgB1:   b1_d       = bus.cfg_wdata;
        CfgXoff: xoff_d     = bus.cfg_wdata;
        CfgW0:   w0_d       = bus.cfg_wdata;
        CfgClr:  clr_pend_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a1_q        <= RstA1;
      b0_q        <= RstB0;
      b1_q        <= RstB1;
      xoff_q      <= RstXoff;
      w0_q        <= RstW0;
      a1_sh_q     <= '0;
      b0_sh_q     <= '0;
      b1_sh_q     <= '0;
      xoff_sh_q   <= '0;
      x_q         <= '0;
      wprev_q     <= '0;
      wacc_q      <= '0;
      yacc_q      <= '0;
      out_y_q     <= '0;
      out_w_q     <= '0;
      out_valid_q <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      xoff_q      <= xoff_d;
      w0_q        <= w0_d;
      a1_sh_q     <= a1_sh_d;
      b0_sh_q     <= b0_sh_d;
      b1_sh_q     <= b1_sh_d;
      xoff_sh_q   <= xoff_sh_d;
      x_q         <= x_d;
      wprev_q     <= wprev_d;
      wacc_q      <= wacc_d;
      yacc_q      <= yacc_d;
      out_y_q     <= out_y_d;
      out_w_q     <= out_w_d;
      out_valid_q <= out_valid_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

endmodule
